// File: rtl/reg_write_arbiter_pkg.sv
// Shared constants and state encoding for the register-file write arbiter.
package reg_write_arbiter_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned NUM_REGS = 8;
    localparam int unsigned ADDR_W   = 3;

    typedef enum logic {
        CLEAR = 1'b0,
        ARB   = 1'b1
    } state_e;

endpackage

// File: rtl/reg_write_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: on a tie, the requester not granted most recently wins.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // last_q = 1 means requester 1 was granted last, so requester 0 wins a tie
    logic last_q;
    logic last_d;

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (advance) begin
            last_d = gnt[1];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Arbitrates ALU and load writebacks onto one register-file write port, with a
// zero-fill sweep of every register after reset or on request.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W   = reg_write_arbiter_pkg::DATA_W,
    parameter int unsigned NUM_REGS = reg_write_arbiter_pkg::NUM_REGS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_dest,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_dest,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              clr_start,
    output logic              regWrt,
    output logic [ADDR_W-1:0] wDest,
    output logic [DATA_W-1:0] wDat,
    output logic              busy
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic                reg_wrt_q, reg_wrt_d;
    logic [ADDR_W-1:0]   w_dest_q, w_dest_d;
    logic [DATA_W-1:0]   w_dat_q, w_dat_d;
    logic                busy_q, busy_d;
    logic                clr_go;
    logic                arb_en;
    logic [1:0]          gnt;

    // busy_q stays high through the cycle showing the last sweep write, so no grant overlaps the sweep
    assign clr_go = clr_start && (state_q == ARB) && !busy_q;
    assign arb_en = (state_q == ARB) && !busy_q && !clr_start;

    rr_arbiter2 u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     ({req1_valid, req0_valid} & {2{arb_en}}),
        .advance (|gnt),
        .gnt     (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign regWrt     = reg_wrt_q;
    assign wDest      = w_dest_q;
    assign wDat       = w_dat_q;
    assign busy       = busy_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
            reg_wrt_q <= 1'b0;
            w_dest_q  <= '0;
            w_dat_q   <= '0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            reg_wrt_q <= reg_wrt_d;
            w_dest_q  <= w_dest_d;
            w_dat_q   <= w_dat_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        unique case (state_q)
            CLEAR: begin
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                if (clr_cnt_q == ADDR_W'(NUM_REGS - 1)) begin
                    state_d   = ARB;
                    clr_cnt_d = '0;
                end
            end
            ARB: begin
                if (clr_go) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_comb begin
        reg_wrt_d = 1'b0;
        w_dest_d  = w_dest_q;
        w_dat_d   = w_dat_q;
        busy_d    = (state_d == CLEAR) || (state_q == CLEAR);
        unique case (state_q)
            CLEAR: begin
                reg_wrt_d = 1'b1;
                w_dest_d  = clr_cnt_q;
                w_dat_d   = '0;
            end
            ARB: begin
                if (gnt[0]) begin
                    reg_wrt_d = 1'b1;
                    w_dest_d  = req0_dest;
                    w_dat_d   = req0_data;
                end else if (gnt[1]) begin
                    reg_wrt_d = 1'b1;
                    w_dest_d  = req1_dest;
                    w_dat_d   = req1_data;
                end
            end
            default: reg_wrt_d = 1'b0;
        endcase
    end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 The block SHALL expose parameter DATA_W, default 16, meaning register data width.
REQ-002 The block SHALL expose parameter NUM_REGS, default 8, meaning register count; the address width is 3 bits.
REQ-003 Port clk SHALL be input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port reset SHALL be input, 1 bit: reset is synchronous and active-low.
REQ-005 Ports req0_valid (input, 1), req0_dest (input, 3), req0_data (input, DATA_W) and req0_ready (output, 1) SHALL form requester 0, the ALU writeback.
REQ-006 Ports req1_valid (input, 1), req1_dest (input, 3), req1_data (input, DATA_W) and req1_ready (output, 1) SHALL form requester 1, the memory-load writeback.
REQ-007 Port clr_start SHALL be input, 1 bit: a one-cycle pulse requesting a register-file clear sweep.
REQ-008 Ports regWrt (output, 1), wDest (output, 3) and wDat (output, DATA_W) SHALL drive the register-file write port.
REQ-009 Port busy SHALL be output, 1 bit: high while a clear sweep is in progress.

Function
REQ-010 The FSM SHALL have exactly two states, CLEAR and ARB.
REQ-011 In CLEAR, each cycle SHALL issue regWrt=1, wDest=clr_cnt and wDat=0.
- clr_cnt increments by 1 per cycle.
- After the write with clr_cnt=NUM_REGS-1, the state goes to ARB and clr_cnt wraps to 0.
REQ-012 In CLEAR, req0_ready and req1_ready SHALL be 0 and busy SHALL be 1.
REQ-013 In ARB, busy SHALL be 0 and reqN_ready SHALL be asserted combinationally for the granted requester only.
- Only req0_valid=1: grant requester 0.
- Only req1_valid=1: grant requester 1.
- Both valid: grant the requester not granted most recently (round-robin pointer).
- Neither valid: no grant.
REQ-014 A transfer SHALL occur when valid and ready are both 1 at a rising edge.
- The round-robin pointer updates only on a transfer.
REQ-015 Write latency SHALL be 1 cycle: a transfer at edge N drives regWrt=1, wDest=dest and wDat=data during cycle N+1.
- Sustained throughput is one write per cycle.
REQ-016 With no transfer at an edge in ARB, the following cycle SHALL have regWrt=0; wDest and wDat hold their last values.
REQ-017 clr_start=1 in ARB SHALL take priority over requests.
- Both readies are 0 that cycle.
- The state goes to CLEAR at the next edge with clr_cnt=0.
- A write already registered from the prior edge still completes.
REQ-018 clr_start asserted while in CLEAR SHALL be ignored; the sweep is not restarted.
REQ-019 The block SHALL NOT alter dest or data; writes to address 0 (m) are legal.
REQ-020 The valid/ready rule SHALL hold: a requester keeps valid, dest and data stable until ready; the block never drops an accepted request.

Reset
REQ-021 While reset=0 at a rising edge, the block SHALL go to state CLEAR with clr_cnt=0, the round-robin pointer favouring requester 0, and regWrt=0, wDest=0, wDat=0.
REQ-022 After reset release, the first cycle SHALL begin the sweep, giving exactly NUM_REGS clear writes (address 0..7) before the first grant.
REQ-023 Reset asserted mid-sweep or mid-transfer SHALL discard all progress and pending writes; the sweep restarts from 0 after release.

Structure
REQ-024 A shared package SHALL hold DATA_W, NUM_REGS, the address width constant and the state enum {CLEAR, ARB}.
REQ-025 The two-way round-robin grant logic SHALL be one sub-module, rr_arbiter2 (inputs req[1:0], advance; output gnt[1:0]).

Verification
REQ-026 Release reset, no requests -> cycles 1-8 regWrt=1, wDest=0..7, wDat=0, busy=1; cycle 9 busy=0 and regWrt=0.
REQ-027 In ARB, req0 alone with dest=4, data=0x1234 -> req0_ready=1 the same cycle; next cycle regWrt=1, wDest=4, wDat=0x1234.
REQ-028 Both valid continuously for 4 cycles, first grant idle -> grant order 0,1,0,1; wDat alternates between req0_data and req1_data.
REQ-029 clr_start with req1 valid in the same cycle -> req1_ready=0; an 8-write zero sweep follows; req1 is then granted and written.
REQ-030 reset=0 at sweep write 3 -> regWrt=0 during reset; after release the sweep restarts at wDest=0.
REQ-031 req0 held valid while busy=1 -> no ready and no write until ARB; then exactly one write of req0's data.
